decode_stage: RTL

//  Instruction decode stage, directly downstream of the IF/ID pipeline register.
//  - Consumes instr/next_pc; splits the 16-bit instruction into fields.
//  - Reads the register file; sign-extends immediates.
//  - Detects load-use and writeback hazards; asserts stall_o back to the fetch pipes.
//  - Registers a decoded bundle into the ID/EX boundary.

---
 rtl/decode_pkg.sv | 46 ++++
 rtl/decode_regfile.sv | 66 ++++++
 rtl/decode_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode encoding, instruction field positions and
// the layout of the control bundle carried into EX.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ADDI = 4'd8,
    OP_LUI  = 4'd9,
    OP_LD   = 4'd10,
    OP_ST   = 4'd11,
    OP_BEQ  = 4'd12,
    OP_JMP  = 4'd13
  } op_e;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  localparam int CTRL_REG_WRITE = 4;
  localparam int CTRL_MEM_READ  = 3;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_BRANCH    = 1;
  localparam int CTRL_JUMP      = 0;

  // First member is the MSB, so the packed value reads {reg_write, mem_read, mem_write, branch, jump}.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/decode_regfile.sv
// 16-entry register file with hard-wired zero r0 and two combinational read ports.
// Build option DECODE_WB_BYPASS_EN: a read of the register being written returns the new data.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [3:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [16];
  logic [DATA_W-1:0] mem_d [16];

  // Next-state of the array: writes to r0 are dropped and r0 is kept at zero.
  always_comb begin
    mem_d = mem_q;
    if (we_i && (waddr_i != 4'd0)) begin
      mem_d[waddr_i] = wdata_i;
    end else begin
      mem_d[0] = {DATA_W{1'b0}};
    end
  end

  // Register array storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports.
  always_comb begin
    if (raddr_a_i == 4'd0) begin
      rdata_a_o = {DATA_W{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
`endif
    end else begin
      rdata_a_o = mem_q[raddr_a_i];
    end

    if (raddr_b_i == 4'd0) begin
      rdata_b_o = {DATA_W{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
`endif
    end else begin
      rdata_b_o = mem_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field split, control decode, hazard stall and the ID/EX register.
// Build option DECODE_WB_BYPASS_EN: forward same-cycle writeback instead of stalling on it.
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [PC_W-1:0]    next_pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               flush_i,
  input  logic               wb_en_i,
  input  logic [3:0]         wb_addr_i,
  input  logic [DATA_W-1:0]  wb_data_i,
  output logic               stall_o,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [3:0]         op_o,
  output logic [3:0]         rd_o,
  output logic [DATA_W-1:0]  rs1_data_o,
  output logic [DATA_W-1:0]  rs2_data_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [4:0]         ctrl_o,
  output logic               illegal_o
);

  logic [3:0]        op_f, rd_f, rs1_f, rs2_f;
  logic [3:0]        addr_a, addr_b;
  logic              use_a, use_b;
  logic [DATA_W-1:0] rdata_a, rdata_b, imm_dec;
  ctrl_t             ctrl_dec;
  logic [3:0]        op_dec, rd_dec;
  logic              illegal_dec;
  logic              lu_hit, wb_hit, stall, issue;

  logic              valid_d, valid_q;
  logic [PC_W-1:0]   pc_d, pc_q;
  logic [3:0]        op_d, op_q, rd_d, rd_q;
  logic [DATA_W-1:0] rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  ctrl_t             ctrl_d, ctrl_q;
  logic              illegal_d, illegal_q;

  assign op_f  = instr_i[OP_HI:OP_LO];
  assign rd_f  = instr_i[RD_HI:RD_LO];
  assign rs1_f = instr_i[RS1_HI:RS1_LO];
  assign rs2_f = instr_i[RS2_HI:RS2_LO];

  // Port A normally reads rs1 (rd for ADDI); port B reads rs2 (rd for ST/BEQ).
  always_comb begin
    addr_a      = rs1_f;
    addr_b      = rs2_f;
    use_a       = 1'b0;
    use_b       = 1'b0;
    imm_dec     = {DATA_W{1'b0}};
    ctrl_dec    = '0;
    op_dec      = op_f;
    rd_dec      = rd_f;
    illegal_dec = 1'b0;
    case (op_f)
      OP_NOP: begin
        op_dec = OP_NOP;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        use_a              = 1'b1;
        use_b              = 1'b1;
        ctrl_dec.reg_write = 1'b1;
      end
      OP_ADDI: begin
        addr_a             = rd_f;
        use_a              = 1'b1;
        imm_dec            = {{(DATA_W-8){instr_i[7]}}, instr_i[7:0]};
        ctrl_dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        imm_dec            = DATA_W'({instr_i[7:0], 8'h00});
        ctrl_dec.reg_write = 1'b1;
      end
      OP_LD: begin
        use_a              = 1'b1;
        imm_dec            = {{(DATA_W-4){instr_i[3]}}, instr_i[3:0]};
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.mem_read  = 1'b1;
      end
      OP_ST: begin
        use_a              = 1'b1;
        addr_b             = rd_f;
        use_b              = 1'b1;
        imm_dec            = {{(DATA_W-4){instr_i[3]}}, instr_i[3:0]};
        ctrl_dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        use_a           = 1'b1;
        addr_b          = rd_f;
        use_b           = 1'b1;
        imm_dec         = {{(DATA_W-4){instr_i[3]}}, instr_i[3:0]};
        ctrl_dec.branch = 1'b1;
      end
      OP_JMP: begin
        imm_dec       = {{(DATA_W-12){instr_i[11]}}, instr_i[11:0]};
        ctrl_dec.jump = 1'b1;
      end
      default: begin
        op_dec      = OP_NOP;
        rd_dec      = 4'd0;
        illegal_dec = 1'b1;
      end
    endcase
  end

  decode_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (wb_en_i),
    .waddr_i   (wb_addr_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (addr_a),
    .rdata_a_o (rdata_a),
    .raddr_b_i (addr_b),
    .rdata_b_o (rdata_b)
  );

  // Only sources the opcode actually reads can raise a hazard.
  always_comb begin
    lu_hit = 1'b0;
    wb_hit = 1'b0;
    if (valid_q && ctrl_q.mem_read && (rd_q != 4'd0)) begin
      lu_hit = (use_a && (addr_a == rd_q)) || (use_b && (addr_b == rd_q));
    end else begin
      lu_hit = 1'b0;
    end
`ifdef DECODE_WB_BYPASS_EN
    wb_hit = 1'b0;
`else
    if (wb_en_i && (wb_addr_i != 4'd0)) begin
      wb_hit = (use_a && (addr_a == wb_addr_i)) || (use_b && (addr_b == wb_addr_i));
    end else begin
      wb_hit = 1'b0;
    end
`endif
    stall = valid_i && !flush_i && !rst_i && (lu_hit || wb_hit);
    issue = valid_i && !flush_i && !stall;
  end

  assign stall_o = stall;

  // ID/EX next value: a fully cleared bubble unless an instruction issues.
  always_comb begin
    valid_d    = 1'b0;
    pc_d       = {PC_W{1'b0}};
    op_d       = 4'd0;
    rd_d       = 4'd0;
    rs1_data_d = {DATA_W{1'b0}};
    rs2_data_d = {DATA_W{1'b0}};
    imm_d      = {DATA_W{1'b0}};
    ctrl_d     = '0;
    illegal_d  = 1'b0;
    if (issue) begin
      valid_d    = 1'b1;
      pc_d       = next_pc_i;
      op_d       = op_dec;
      rd_d       = rd_dec;
      rs1_data_d = use_a ? rdata_a : {DATA_W{1'b0}};
      rs2_data_d = use_b ? rdata_b : {DATA_W{1'b0}};
      imm_d      = imm_dec;
      ctrl_d     = ctrl_dec;
      illegal_d  = illegal_dec;
    end else begin
      valid_d = 1'b0;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      pc_q       <= {PC_W{1'b0}};
      op_q       <= 4'd0;
      rd_q       <= 4'd0;
      rs1_data_q <= {DATA_W{1'b0}};
      rs2_data_q <= {DATA_W{1'b0}};
      imm_q      <= {DATA_W{1'b0}};
      ctrl_q     <= '0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
      illegal_q  <= illegal_d;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign op_o       = op_q;
  assign rd_o       = rd_q;
  assign rs1_data_o = rs1_data_q;
  assign rs2_data_o = rs2_data_q;
  assign imm_o      = imm_q;
  assign ctrl_o     = ctrl_q;
  assign illegal_o  = illegal_q;

endmodule
